nios_system_wdone_engine: RTL
=============================

Name: nios_system_wdone_engine

Overview:
Write engine that sits directly upstream of the write-done PIO input port. It takes a start command (base address, word count), accepts data words over a valid/ready stream and writes them to on-chip memory through a simple Avalon-style master with waitrequest. It drives the 8-bit wdone status vector that the PIO samples for the Nios II: done, busy, error and a completed-transfer counter.

Parameters:
ADDR_W, 16, memory word-address width
LEN_W, 16, width of the transfer length (words)
DATA_W, 32, data word width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle command pulse
base_addr  in  ADDR_W  first word address, sampled on an accepted start
length  in  LEN_W  number of words, sampled on an accepted start
clear  in  1  pulse: clears the done and err status bits
din_data  in  DATA_W  stream data
din_valid  in  1  stream data valid
din_ready  out  1  engine can take a stream word
mem_address  out  ADDR_W  write word address
mem_writedata  out  DATA_W  write data
mem_write  out  1  write request
mem_waitrequest  in  1  memory stall
wdone  out  8  status: [0] done, [1] busy, [2] err, [7:3] completed-transfer count mod 32

Behaviour:
- Reset (sampled on the clk edge while reset=1): state IDLE. All outputs and internal registers go to 0, including din_ready, mem_write, mem_address, mem_writedata and wdone. Reset mid-transfer aborts it immediately: mem_write is 0 on the next cycle and the done count does not change.
- States are IDLE, FETCH, WRITE and FINISH. All outputs are registered.
- IDLE:
  - start=1 with length!=0 latches base_addr into the address register and length into the remaining-count register, sets busy, clears done, then goes to FETCH.
  - start=1 with length=0 goes to FINISH and performs no memory write.
- FETCH: din_ready=1. When din_valid=1 and din_ready=1, din_data is latched into mem_writedata, mem_write is set to 1 and the state goes to WRITE. din_ready is 0 in the cycle after the accept.
- WRITE: mem_write stays 1 and mem_address and mem_writedata stay stable while mem_waitrequest=1. In the cycle where mem_waitrequest=0 the write completes:
  - The address is incremented by 1, wrapping modulo 2^ADDR_W.
  - remaining is decremented.
  - mem_write goes to 0.
  - If the new remaining=0 the state goes to FINISH; otherwise it goes to FETCH.
- FINISH: lasts one cycle. Sets done=1, clears busy, increments wdone[7:3] (wraps 31 to 0), then returns to IDLE.
- Throughput: at most one word every 2 cycles (FETCH accept, then WRITE with no wait states).
- Latency: the first mem_write rises 1 cycle after the stream accept. done rises 2 cycles after the last write completes (the FINISH transition cycle, then the FINISH cycle).
- start while busy (any state other than IDLE): the command is ignored, err is set to 1, and the transfer in flight continues unaffected.
- clear: sets done=0 and err=0 on the next edge.
  - clear and FINISH in the same cycle: done=1 wins. The count still increments.
  - clear and an erroring start in the same cycle: err=1 wins.
  - clear and a valid start in IDLE: the start is accepted.
- din_valid while not in FETCH is ignored; no data is consumed.
- wdone holds its value between events. done and err are sticky.

Test Plan:
- Basic transfer: start with base=0x0010 and len=3, din_valid held high, waitrequest=0. Writes go to 0x0010, 0x0011, 0x0012 with the streamed data, one write every 2 cycles. Then wdone = 8'b0000_1001 (done=1, count=1).
- Wait states: waitrequest high for 4 cycles on the 2nd word. mem_write, address and data stay stable for 5 cycles, exactly one write is counted per word, and no extra din accepts occur.
- Zero length: start with len=0. No mem_write at any point. wdone shows done=1 and the count incremented, 2 cycles after start.
- Busy collision: a second start in the middle of a len=4 transfer. err=1, the original 4 writes complete at the original addresses, and wdone=8'b0000_1101. A following clear returns wdone to 8'b0000_1000.
- Address wrap: base=0xFFFF and len=2 with ADDR_W=16. Writes go to 0xFFFF, then 0x0000.
- Reset mid-operation: assert reset while in WRITE with waitrequest=1. On the next cycle mem_write=0, din_ready=0 and wdone=0. A new start afterwards runs normally.
- Count wrap: 32 zero-length transfers bring wdone[7:3] back to 0.

Source files
------------

// File: rtl/nios_system_wdone_engine.sv
// Stream-to-memory write engine feeding the write-done PIO status vector.
// Takes a (base, length) command, accepts stream words and writes them through an Avalon-style master.
module nios_system_wdone_engine #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              clear,
    input  logic [DATA_W-1:0] din_data,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_write,
    input  logic              mem_waitrequest,
    output logic [7:0]        wdone
);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, FINISH} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ready_q, ready_d;
    logic              wr_q, wr_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              accept;
    logic              wr_ok;

    assign accept = (state == FETCH) && din_valid && ready_q;
    assign wr_ok  = (state == WRITE) && !mem_waitrequest;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (length != '0) ? FETCH : FINISH;
                end
            end
            FETCH: begin
                if (accept) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                // remaining reaches zero with this write when it is currently one
                if (wr_ok) begin
                    state_nxt = (rem_q == LEN_W'(1)) ? FINISH : FETCH;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        done_d  = done_q;
        busy_d  = busy_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        ready_d = (state_nxt == FETCH);
        wr_d    = (state_nxt == WRITE);

        // clear first so that a same-cycle done or err event takes priority
        if (clear) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (start && (state != IDLE)) begin
            err_d = 1'b1;
        end

        case (state)
            IDLE: begin
                if (start && (length != '0)) begin
                    addr_d = base_addr;
                    rem_d  = length;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                end
            end
            FETCH: begin
                if (accept) begin
                    data_d = din_data;
                end
            end
            WRITE: begin
                if (wr_ok) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - LEN_W'(1);
                end
            end
            FINISH: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                cnt_d  = cnt_q + 5'd1;
            end
            default: ;
        endcase
    end

    assign din_ready     = ready_q;
    assign mem_write     = wr_q;
    assign mem_address   = addr_q;
    assign mem_writedata = data_q;
    assign wdone         = {cnt_q, err_q, busy_q, done_q};

endmodule
